// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache refill path and the dcache refill/write-back path onto
// one memory request/response channel, one transaction in flight at a time.
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic              ic_req_valid,
   output logic              ic_req_ready,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   input  logic              dc_req_valid,
   output logic              dc_req_ready,
   input  logic              dc_req_rnw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [DATA_W-1:0] dc_req_data,
   input  logic [MASK_W-1:0] dc_req_mask,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rnw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_data,
   output logic [MASK_W-1:0] mem_req_mask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              busy,
   output logic              spurious_resp
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; the sender holds valid and payload stable until then.

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic              last_grant_dc;
   logic              owner_dc;
   logic              sel_dc;
   logic              grant_ok;
   logic              accept;
   logic              resp_cap;
   logic              rnw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [MASK_W-1:0] mask_q;

   // On a tie the side that was not granted last wins.
   assign sel_dc       = dc_req_valid && (!ic_req_valid || !last_grant_dc);
   assign grant_ok     = (state == IDLE) && init_done;
   assign ic_req_ready = grant_ok && ic_req_valid && !sel_dc;
   assign dc_req_ready = grant_ok && sel_dc;
   assign accept       = ic_req_ready || dc_req_ready;
   assign resp_cap     = (state == WAIT_RESP) && mem_resp_valid;

   assign mem_req_valid = (state == ISSUE);
   assign mem_req_rnw   = rnw_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_data  = data_q;
   assign mem_req_mask  = mask_q;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (accept) state_nxt = ISSUE;
         ISSUE:     if (mem_req_ready) state_nxt = rnw_q ? WAIT_RESP : IDLE;
         WAIT_RESP: if (mem_resp_valid) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_dc <= 1'b0;
         owner_dc      <= 1'b0;
         rnw_q         <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         mask_q        <= '0;
      end else if (accept) begin
         last_grant_dc <= dc_req_ready;
         owner_dc      <= dc_req_ready;
         if (dc_req_ready) begin
            rnw_q  <= dc_req_rnw;
            addr_q <= dc_req_addr;
            data_q <= dc_req_data;
            mask_q <= dc_req_rnw ? {MASK_W{1'b1}} : dc_req_mask;
         end else begin
            rnw_q  <= 1'b1;
            addr_q <= ic_req_addr;
            data_q <= '0;
            mask_q <= {MASK_W{1'b1}};
         end
      end
   end

   // Responses go back to whoever owns the in-flight read; data holds between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ic_resp_valid <= 1'b0;
         dc_resp_valid <= 1'b0;
         ic_resp_data  <= '0;
         dc_resp_data  <= '0;
         spurious_resp <= 1'b0;
      end else begin
         ic_resp_valid <= resp_cap && !owner_dc;
         dc_resp_valid <= resp_cap && owner_dc;
         if (resp_cap && owner_dc)  dc_resp_data <= mem_resp_data;
         if (resp_cap && !owner_dc) ic_resp_data <= mem_resp_data;
         if (mem_resp_valid && (state != WAIT_RESP)) spurious_resp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grant table, transaction table and
// hand-written sequences for ties, stalls, spurious responses and reset.
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 128;
   localparam int MW = 16;

   logic          clk;
   logic          rst;
   logic          init_done;
   logic          ic_req_valid;
   logic          ic_req_ready;
   logic [AW-1:0] ic_req_addr;
   logic          ic_resp_valid;
   logic [DW-1:0] ic_resp_data;
   logic          dc_req_valid;
   logic          dc_req_ready;
   logic          dc_req_rnw;
   logic [AW-1:0] dc_req_addr;
   logic [DW-1:0] dc_req_data;
   logic [MW-1:0] dc_req_mask;
   logic          dc_resp_valid;
   logic [DW-1:0] dc_resp_data;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_rnw;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_data;
   logic [MW-1:0] mem_req_mask;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;
   logic          busy;
   logic          spurious_resp;

   cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rnw(dc_req_rnw),
      .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy), .spurious_resp(spurious_resp)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   // Called just after driving a request; returns holding it with ready high.
   task automatic wait_ready(input logic is_dc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (is_dc ? dc_req_ready : ic_req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("grant_wait", ok, 1'b1);
   endtask

   task automatic issue(input logic is_dc, input logic rnw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [MW-1:0] mask);
      tick();
      if (is_dc) begin
         dc_req_valid = 1'b1; dc_req_rnw = rnw; dc_req_addr = addr;
         dc_req_data = data;  dc_req_mask = mask;
      end else begin
         ic_req_valid = 1'b1; ic_req_addr = addr;
      end
      wait_ready(is_dc);
      tick();
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
   endtask

   // Memory side of one accepted transaction; starts in the cycle after acceptance.
   task automatic serve(input string tag, input logic rnw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [MW-1:0] mask,
                        input int stall, input int delay, input logic [DW-1:0] rdata,
                        input logic to_dc);
      @(negedge clk);
      chk({tag, ".mvalid"}, mem_req_valid, 1'b1);
      chk({tag, ".addr"}, mem_req_addr, addr);
      chk({tag, ".rnw"}, mem_req_rnw, rnw);
      chk({tag, ".mask"}, mem_req_mask, mask);
      if (!rnw) chk({tag, ".wdata"}, mem_req_data, data);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".rdy_off"}, {ic_req_ready, dc_req_ready}, 2'b00);
      for (int s = 0; s < stall; s++) begin
         tick();
         @(negedge clk);
         chk({tag, ".stall_valid"}, mem_req_valid, 1'b1);
         chk({tag, ".stall_addr"}, mem_req_addr, addr);
         chk({tag, ".stall_mask"}, mem_req_mask, mask);
         if (!rnw) chk({tag, ".stall_data"}, mem_req_data, data);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".mvalid_off"}, mem_req_valid, 1'b0);
      chk({tag, ".busy_after_req"}, busy, rnw);
      if (rnw) begin
         repeat (delay) @(negedge clk);
         mem_resp_valid = 1'b1;
         mem_resp_data  = rdata;
         tick();
         mem_resp_valid = 1'b0;
         @(negedge clk);
         chk({tag, ".own_rvalid"}, to_dc ? dc_resp_valid : ic_resp_valid, 1'b1);
         chk({tag, ".own_rdata"}, to_dc ? dc_resp_data : ic_resp_data, rdata);
         chk({tag, ".other_rvalid"}, to_dc ? ic_resp_valid : dc_resp_valid, 1'b0);
         chk({tag, ".busy_done"}, busy, 1'b0);
         @(negedge clk);
         chk({tag, ".rvalid_pulse"}, to_dc ? dc_resp_valid : ic_resp_valid, 1'b0);
      end else begin
         chk({tag, ".no_resp"}, {ic_resp_valid, dc_resp_valid}, 2'b00);
         @(negedge clk);
         chk({tag, ".no_resp2"}, {ic_resp_valid, dc_resp_valid}, 2'b00);
      end
   endtask

   typedef struct {
      logic init; logic icv; logic dcv; logic exp_ic; logic exp_dc;
   } gvec_t;

   typedef struct {
      logic is_dc; logic rnw; logic [AW-1:0] addr; logic [DW-1:0] wdata;
      logic [MW-1:0] mask; int stall; int delay; logic [DW-1:0] rdata;
   } txn_t;

   gvec_t gv[6];
   txn_t  tx[4];

   initial begin
      logic [MW-1:0] exp_mask;
      logic          exp_rnw;

      // last_grant is IC when the grant table runs, so a tie must go to the dcache
      gv[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      gv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      gv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      gv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      gv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      gv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      tx[0] = '{1'b1, 1'b0, 32'h0000_4000, 128'hDEADBEEF_01234567_89ABCDEF_00112233,
                16'h000F, 5, 0, 128'h0};
      tx[1] = '{1'b0, 1'b1, 32'h0000_5000, 128'h0, 16'hFFFF, 0, 10,
                128'hCAFE0000_11112222_33334444_55556666};
      tx[2] = '{1'b1, 1'b1, 32'h0000_6000, 128'h0, 16'h1234, 2, 3,
                128'h0BAD0000_AAAABBBB_CCCCDDDD_EEEEFFFF};
      tx[3] = '{1'b0, 1'b1, 32'h0000_7000, 128'h0, 16'hFFFF, 1, 1,
                128'h12345678_9ABCDEF0_0FEDCBA9_87654321};

      rst = 1'b0; init_done = 1'b0;
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
      dc_req_valid = 1'b0; dc_req_rnw = 1'b1; dc_req_addr = '0; dc_req_data = '0; dc_req_mask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

      // outputs during reset
      #12;
      chk("rst.mvalid", mem_req_valid, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.spurious", spurious_resp, 1'b0);
      chk("rst.rvalids", {ic_resp_valid, dc_resp_valid}, 2'b00);
      chk("rst.mask", mem_req_mask, 16'h0);
      chk("rst.readies", {ic_req_ready, dc_req_ready}, 2'b00);
      @(negedge clk);
      rst = 1'b1;

      // no grant while memory initialisation is pending
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("init.ic_ready", ic_req_ready, 1'b0);
         chk("init.mvalid", mem_req_valid, 1'b0);
      end
      init_done = 1'b1;
      #1;
      chk("init.ic_ready_up", ic_req_ready, 1'b1);
      tick();
      ic_req_valid = 1'b0;
      serve("init", 1'b1, 32'h0000_1000, '0, 16'hFFFF, 0, 2, 128'h5A5A, 1'b0);

      // combinational grant table
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         init_done = gv[i].init; ic_req_valid = gv[i].icv; dc_req_valid = gv[i].dcv;
         #1;
         chk($sformatf("grant[%0d].ic", i), ic_req_ready, gv[i].exp_ic);
         chk($sformatf("grant[%0d].dc", i), dc_req_ready, gv[i].exp_dc);
         ic_req_valid = 1'b0; dc_req_valid = 1'b0; init_done = 1'b1;
      end

      // transaction table
      for (int i = 0; i < 4; i++) begin
         exp_mask = tx[i].rnw ? 16'hFFFF : tx[i].mask;
         exp_rnw  = tx[i].is_dc ? tx[i].rnw : 1'b1;
         issue(tx[i].is_dc, tx[i].rnw, tx[i].addr, tx[i].wdata, tx[i].mask);
         serve($sformatf("txn[%0d]", i), exp_rnw, tx[i].addr, tx[i].wdata, exp_mask,
               tx[i].stall, tx[i].delay, tx[i].rdata, tx[i].is_dc);
      end

      // round robin after a fresh reset
      do_reset();
      tick();
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_2000;
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 32'h0000_3000;
      #1;
      chk("tie1.dc_ready", dc_req_ready, 1'b1);
      chk("tie1.ic_ready", ic_req_ready, 1'b0);
      tick();
      dc_req_valid = 1'b0;
      serve("tie1", 1'b1, 32'h0000_3000, '0, 16'hFFFF, 1, 2, 128'hD1, 1'b1);
      ic_req_valid = 1'b0;
      serve("tie2", 1'b1, 32'h0000_2000, '0, 16'hFFFF, 0, 1, 128'hA2, 1'b0);
      tick();
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_2100;
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 32'h0000_3100;
      #1;
      chk("tie3.dc_ready", dc_req_ready, 1'b1);
      chk("tie3.ic_ready", ic_req_ready, 1'b0);
      tick();
      dc_req_valid = 1'b0; ic_req_valid = 1'b0;
      serve("tie3", 1'b1, 32'h0000_3100, '0, 16'hFFFF, 0, 1, 128'hD3, 1'b1);

      // init_done dropping mid-transaction
      issue(1'b1, 1'b0, 32'h0000_9000, 128'h77, 16'h00F0);
      init_done = 1'b0;
      serve("init_drop", 1'b0, 32'h0000_9000, 128'h77, 16'h00F0, 2, 0, '0, 1'b1);
      tick();
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_A000;
      repeat (3) begin
         @(negedge clk);
         chk("init_drop.no_grant", ic_req_ready, 1'b0);
      end
      init_done = 1'b1;
      #1;
      chk("init_drop.regrant", ic_req_ready, 1'b1);
      ic_req_valid = 1'b0;

      // response while idle
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_resp_data = 128'hBAD;
      tick();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("spur.flag", spurious_resp, 1'b1);
      chk("spur.no_rvalid", {ic_resp_valid, dc_resp_valid}, 2'b00);
      repeat (3) @(negedge clk);
      chk("spur.sticky", spurious_resp, 1'b1);

      // reset while waiting for a read response
      do_reset();
      @(negedge clk);
      chk("rst2.spur_clear", spurious_resp, 1'b0);
      issue(1'b0, 1'b1, 32'h0000_8000, '0, '0);
      @(negedge clk);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("rst2.wait_busy", busy, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst2.busy", busy, 1'b0);
      chk("rst2.mvalid", mem_req_valid, 1'b0);
      chk("rst2.addr", mem_req_addr, 32'h0);
      chk("rst2.ic_rdata", ic_resp_data, 128'h0);
      chk("rst2.dc_rdata", dc_resp_data, 128'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_resp_data = 128'hFEED;
      tick();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("rst2.no_rvalid", {ic_resp_valid, dc_resp_valid}, 2'b00);
      chk("rst2.spur", spurious_resp, 1'b1);
      chk("rst2.rdata_kept", ic_resp_data, 128'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
